// File: rtl/sid_regs_if.sv
// SID CPU-side register bus: chip select, direction, address and data.
// The bus arbiter drives the master side; sid_regs takes the slave side.
interface sid_regs_if;
    logic       cs;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output cs, we, addr, data_in,
        input  data_out
    );

    modport slave (
        input  cs, we, addr, data_in,
        output data_out
    );
endinterface

// File: rtl/sid_regs.sv
// SID register responder: voice/filter/volume write decode, OSC3/ENV3/POT
// readback and the decaying floating bus value.
module sid_regs #(
    parameter int DECAY_6581 = 7424,
    parameter int DECAY_8580 = 41000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic        mode,
    sid_regs_if.slave   bus,
    input  logic [7:0]  osc3,
    input  logic [7:0]  env3,
    input  logic [7:0]  pot_x,
    input  logic [7:0]  pot_y,
    output logic [47:0] freq,
    output logic [35:0] pw,
    output logic [23:0] control,
    output logic [23:0] att_dec,
    output logic [23:0] sus_rel,
    output logic [10:0] fc,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol
);

    logic [47:0] freq_q;
    logic [35:0] pw_q;
    logic [23:0] control_q;
    logic [23:0] att_dec_q;
    logic [23:0] sus_rel_q;
    logic [10:0] fc_q;
    logic [7:0]  res_filt_q;
    logic [7:0]  mode_vol_q;
    logic [7:0]  data_out_q;
    logic [7:0]  bus_q, bus_d;
    logic [19:0] cnt_q, cnt_d;

    logic        wr, rd, rd_live;
    logic [7:0]  rd_byte;
    logic [19:0] reload;
    logic        vhit;
    logic [1:0]  vsel;
    logic [2:0]  voff;
    logic [5:0]  fbase;
    logic [5:0]  pbase;
    logic [4:0]  cbase;

    assign wr     = ce_1m & bus.cs & bus.we;
    assign rd     = ce_1m & bus.cs & ~bus.we;
    assign reload = mode ? 20'(DECAY_8580) : 20'(DECAY_6581);

    always_comb begin
        rd_live = 1'b1;
        rd_byte = bus_q;
        unique case (bus.addr)
            5'h19:   rd_byte = pot_x;
            5'h1A:   rd_byte = pot_y;
            5'h1B:   rd_byte = osc3;
            5'h1C:   rd_byte = env3;
            default: rd_live = 1'b0;
        endcase
        rd_live = rd_live & rd;
    end

    // Voice registers sit at 7v + offset for v = 0..2.
    always_comb begin
        vhit = 1'b1;
        vsel = 2'd0;
        voff = 3'd0;
        if (bus.addr < 5'd7) begin
            voff = bus.addr[2:0];
        end else if (bus.addr < 5'd14) begin
            vsel = 2'd1;
            voff = 3'(bus.addr - 5'd7);
        end else if (bus.addr < 5'd21) begin
            vsel = 2'd2;
            voff = 3'(bus.addr - 5'd14);
        end else begin
            vhit = 1'b0;
        end
        fbase = {vsel, 4'd0};
        pbase = 6'(vsel) * 6'd12;
        cbase = {vsel, 3'd0};
    end

    // A write beats a same-tick expiry; only live reads refresh the count.
    always_comb begin
        bus_d = bus_q;
        cnt_d = cnt_q;
        if (wr) begin
            bus_d = bus.data_in;
            cnt_d = reload;
        end else if (rd_live) begin
            bus_d = rd_byte;
            cnt_d = reload;
        end else if (ce_1m && cnt_q != 20'd0) begin
            cnt_d = cnt_q - 20'd1;
            if (cnt_q == 20'd1) begin
                bus_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            freq_q     <= '0;
            pw_q       <= '0;
            control_q  <= '0;
            att_dec_q  <= '0;
            sus_rel_q  <= '0;
            fc_q       <= '0;
            res_filt_q <= '0;
            mode_vol_q <= '0;
            data_out_q <= '0;
            bus_q      <= '0;
            cnt_q      <= '0;
        end else begin
            bus_q <= bus_d;
            cnt_q <= cnt_d;
            if (rd) begin
                data_out_q <= rd_byte;
            end
            if (wr && vhit) begin
                unique case (voff)
                    3'd0: freq_q[fbase +: 8]        <= bus.data_in;
                    3'd1: freq_q[fbase + 6'd8 +: 8] <= bus.data_in;
                    3'd2: pw_q[pbase +: 8]          <= bus.data_in;
                    3'd3: pw_q[pbase + 6'd8 +: 4]   <= bus.data_in[3:0];
                    3'd4: control_q[cbase +: 8]     <= bus.data_in;
                    3'd5: att_dec_q[cbase +: 8]     <= bus.data_in;
                    3'd6: sus_rel_q[cbase +: 8]     <= bus.data_in;
                    default: ;
                endcase
            end
            if (wr) begin
                unique case (bus.addr)
                    5'h15:   fc_q[2:0]  <= bus.data_in[2:0];
                    5'h16:   fc_q[10:3] <= bus.data_in;
                    5'h17:   res_filt_q <= bus.data_in;
                    5'h18:   mode_vol_q <= bus.data_in;
                    default: ;
                endcase
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign freq         = freq_q;
    assign pw           = pw_q;
    assign control      = control_q;
    assign att_dec      = att_dec_q;
    assign sus_rel      = sus_rel_q;
    assign fc           = fc_q;
    assign res_filt     = res_filt_q;
    assign mode_vol     = mode_vol_q;

endmodule
